// File: rtl/gP.sv
// Shared core definitions: fetch FSM states, decoder opcodes and instruction field positions.
package gP;

    typedef enum logic [1:0] {
        RESET = 2'd0,
        REQ   = 2'd1,
        HOLD  = 2'd2
    } fetch_state_t;

    // Opcodes that the fetch path and the control decoder agree on
    localparam logic [3:0] OP_LDR = 4'd0;
    localparam logic [3:0] OP_STR = 4'd1;
    localparam logic [3:0] OP_BEQ = 4'd11;
    localparam logic [3:0] OP_BNE = 4'd12;
    localparam logic [3:0] OP_JMP = 4'd13;

    localparam int OPC_MSB = 15;
    localparam int OPC_LSB = 12;
    localparam int TGT_MSB = 11;
    localparam int TGT_LSB = 0;

endpackage

// File: rtl/branch_target.sv
// Next-PC selection: absolute jump within the current 4K page, PC-relative branch, or sequential.
module branch_target import gP::*; #(
    parameter int OFS_W = 6
) (
    input  logic [15:0]              pc,
    input  logic [TGT_MSB:TGT_LSB]   target,
    input  logic                     jmp,
    input  logic                     beq,
    input  logic                     bne,
    input  logic                     zero,
    output logic [15:0]              next_pc
);

    logic [15:0] seq_pc;
    logic [15:0] ofs_sext;
    logic        taken;

    assign seq_pc   = pc + 16'd1;
    assign ofs_sext = {{(16-OFS_W){target[OFS_W-1]}}, target[OFS_W-1:0]};

    always_comb begin
        // BEQ wins if the decoder ever raises both conditional flags
        taken = beq ? zero : (bne & ~zero);
        if (jmp)
            next_pc = {pc[OPC_MSB:OPC_LSB], target};
        else if (taken)
            next_pc = seq_pc + ofs_sext;
        else
            next_pc = seq_pc;
    end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch sequencer: owns the PC, fetches one word at a time, holds it until accepted.
module fetch_unit import gP::*; #(
    parameter logic [15:0] RESET_PC = 16'h0000,
    parameter int          OFS_W    = 6
) (
    input  logic        CLK,
    input  logic        RST_N,
    output logic        IMEM_REQ,
    output logic [15:0] IMEM_ADDR,
    input  logic        IMEM_ACK,
    input  logic [15:0] IMEM_RDATA,
    output logic [15:0] INSTR,
    output logic [3:0]  OPCODE,
    output logic [15:0] PC,
    output logic        INSTR_VALID,
    input  logic        INSTR_READY,
    input  logic        JMP,
    input  logic        BEQ,
    input  logic        BNE,
    input  logic        ZERO
);

    fetch_state_t state, state_nxt;
    logic [15:0]  fetch_pc;
    logic [15:0]  pc_q;
    logic [15:0]  instr_q;
    logic [15:0]  next_pc;

    branch_target #(.OFS_W(OFS_W)) u_branch_target (
        .pc      (pc_q),
        .target  (instr_q[TGT_MSB:TGT_LSB]),
        .jmp     (JMP),
        .beq     (BEQ),
        .bne     (BNE),
        .zero    (ZERO),
        .next_pc (next_pc)
    );

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state    <= RESET;
            fetch_pc <= RESET_PC;
            pc_q     <= RESET_PC;
            instr_q  <= 16'h0000;
        end else begin
            state <= state_nxt;
            if (state == REQ && IMEM_ACK) begin
                instr_q <= IMEM_RDATA;
                pc_q    <= fetch_pc;
            end
            // Flags are only trusted on the accept edge, when they describe instr_q
            if (state == HOLD && INSTR_READY)
                fetch_pc <= next_pc;
        end
    end

    always_comb begin
        state_nxt   = state;
        IMEM_REQ    = 1'b0;
        INSTR_VALID = 1'b0;
        case (state)
            RESET: state_nxt = REQ;
            REQ: begin
                IMEM_REQ = 1'b1;
                if (IMEM_ACK)
                    state_nxt = HOLD;
            end
            HOLD: begin
                INSTR_VALID = 1'b1;
                if (INSTR_READY)
                    state_nxt = REQ;
            end
            default: state_nxt = RESET;
        endcase
    end

    assign IMEM_ADDR = fetch_pc;
    assign INSTR     = instr_q;
    assign OPCODE    = instr_q[OPC_MSB:OPC_LSB];
    assign PC        = pc_q;

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction fetch sequencer for the 16-bit RISC core. It owns the program counter and issues word reads to instruction memory over a request/acknowledge handshake. It holds each fetched instruction in a one-entry buffer and presents its opcode to the control decoder. It consumes the decoder's JMP/BEQ/BNE flags and the ALU zero flag to select the next PC, so it is the producer of `OPCODE` and the consumer of the branch flags.

## Interface
- `RESET_PC`, default 16'h0000: first fetch address after reset.
- `OFS_W`, default 6: width of the signed branch offset field at `INSTR[OFS_W-1:0]`.
- `CLK`  in  1  single clock; all state updates on the rising edge.
- `RST_N`  in  1  reset; asynchronous, active-low.
- `IMEM_REQ`  out  1  read request to instruction memory.
- `IMEM_ADDR`  out  16  word address; stable while `IMEM_REQ` is high.
- `IMEM_ACK`  in  1  read data valid this cycle.
- `IMEM_RDATA`  in  16  instruction word; sampled only when `IMEM_REQ && IMEM_ACK`.
- `INSTR`  out  16  buffered instruction.
- `OPCODE`  out  4  equals `INSTR[15:12]`; drives the control decoder.
- `PC`  out  16  address of the instruction in `INSTR`.
- `INSTR_VALID`  out  1  buffer holds an unconsumed instruction.
- `INSTR_READY`  in  1  downstream accepts `INSTR` this cycle.
- `JMP`, `BEQ`, `BNE`  in  1 each  decoder flags for the instruction currently in `INSTR`.
- `ZERO`  in  1  ALU zero flag for the instruction currently in `INSTR`.

## Operation
- States: RESET, REQ, HOLD.
- RESET
  - Entered asynchronously while `RST_N` is low.
  - Outputs during reset: `IMEM_REQ`=0, `IMEM_ADDR`=`RESET_PC`, `INSTR`=16'h0000, `PC`=`RESET_PC`, `INSTR_VALID`=0.
  - On the first edge with `RST_N` high, the unit goes to REQ.
- REQ
  - `IMEM_REQ`=1 and `IMEM_ADDR`=the fetch PC.
  - On `IMEM_ACK`: `IMEM_RDATA` is captured into `INSTR`, the fetch PC is copied to `PC`, and the unit goes to HOLD.
  - Otherwise the unit stays in REQ with the address held.
- HOLD
  - `INSTR_VALID`=1 and `IMEM_REQ`=0.
  - The state holds until `INSTR_READY`=1. On that accept edge the fetch PC is loaded with the next PC and the unit goes to REQ.
- Next PC is evaluated on the accept edge only, from the buffered `PC` and `INSTR`:
  - `JMP`=1: `{PC[15:12], INSTR[11:0]}`.
  - `BEQ && ZERO` or `BNE && !ZERO`: `PC + 1 + sext(INSTR[OFS_W-1:0])`.
  - Otherwise: `PC + 1`.
- Flag priority is `JMP` > `BEQ`/`BNE`. Setting `BEQ` and `BNE` together is illegal; the implementation evaluates `BEQ` first.
- All PC arithmetic is modulo 2^16. 16'hFFFF + 1 wraps to 16'h0000. Negative offsets wrap below 0.
- `IMEM_ACK` is ignored outside REQ.
- `JMP`/`BEQ`/`BNE`/`ZERO` are ignored outside the accept edge.
- There is no prefetch, so a taken branch never needs a flush.
- Reset asserted mid-request abandons the request without waiting for `IMEM_ACK`. Instruction memory must tolerate a dropped request.

## Timing
- `IMEM_ACK` may arrive in the same cycle `IMEM_REQ` rises, which gives `INSTR_VALID` on the next cycle.
- Best-case throughput is one instruction every 2 cycles: accept → REQ+ACK → HOLD.
- Fetch latency is one cycle from the ACK edge to `INSTR_VALID`. Each added wait cycle on `IMEM_ACK` adds one cycle.
- `INSTR`, `OPCODE` and `PC` are registered and stable throughout HOLD.
- The control flags and `ZERO` are combinational from `INSTR`. They must settle within the accept cycle.
- `INSTR_VALID` does not depend combinationally on `INSTR_READY`.

## Structure
- Add to shared package `gP`:
  - fetch state enum `fetch_state_t` {RESET, REQ, HOLD};
  - the opcode constants shared with the decoder (LDR=0, STR=1, BEQ=11, BNE=12, JMP=13);
  - field positions (opcode [15:12], jump target [11:0]).
- One combinational sub-module `branch_target` computes the next PC from `PC`, `INSTR`, the flags and `ZERO`. The FSM and registers stay in `fetch_unit`.

## Test plan
- Reset release: `RESET_PC`=16'h0010, memory always acks → `IMEM_ADDR` sequence 0x0010, 0x0011, 0x0012 with `READY` held high. One instruction every 2 cycles.
- Wait states: ACK delayed 3 cycles at address 0x0005 → `IMEM_ADDR` held at 0x0005 with `IMEM_REQ` high for 4 cycles. `INSTR_VALID` rises the cycle after the ACK.
- Backpressure: `INSTR_READY`=0 for 5 cycles with `INSTR`=16'h3123 → `INSTR`, `PC` and `OPCODE`=4'h3 stable, and no `IMEM_REQ`.
- Branches at `PC`=0x0020:
  - `INSTR`=16'hB03E (BEQ, offset −2), `ZERO`=1 → next fetch 0x001F.
  - Same instruction with `ZERO`=0 → 0x0021.
  - BNE, offset +5, `ZERO`=0 → 0x0026.
- Jump and wrap:
  - `PC`=0x7FF0, `INSTR`=16'hDABC with `JMP` → next fetch 0x7ABC.
  - `PC`=0xFFFF with no branch → next fetch 0x0000.
- Mid-request reset: `RST_N` low in REQ at 0x0042, with ACK arriving during reset → all outputs at reset values immediately. After release, the first fetch is `RESET_PC` and the stale data is never captured.
